// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT input framer and its sample banks.
package fft_pkg;

    localparam int IN_WIDTH = 10;
    localparam int NUM      = 16;
    localparam int DATA     = 256;
    localparam int COUNT    = DATA / NUM;
    localparam int WR_AW    = $clog2(DATA);
    localparam int RD_AW    = $clog2(COUNT);
    localparam int LANE_AW  = $clog2(NUM);

    typedef logic [2*IN_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        BK_EMPTY,
        BK_FILL,
        BK_FULL,
        BK_DRAIN
    } bank_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_DRAIN,
        RD_GAP
    } rd_state_t;

    // Stored samples keep the real part in the upper half.
    function automatic sample_t pack_sample(input logic signed [IN_WIDTH-1:0] re,
                                            input logic signed [IN_WIDTH-1:0] im);
        return {re, im};
    endfunction

    function automatic logic signed [IN_WIDTH-1:0] sample_re(input sample_t s);
        return signed'(s[2*IN_WIDTH-1:IN_WIDTH]);
    endfunction

    function automatic logic signed [IN_WIDTH-1:0] sample_im(input sample_t s);
        return signed'(s[IN_WIDTH-1:0]);
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of sample storage: single-sample write port, NUM-lane word read port.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [WR_AW-1:0] waddr,
    input  sample_t          wdata,
    input  logic [RD_AW-1:0] raddr,
    output sample_t          rdata [0:NUM-1]
);

    sample_t mem_q [0:DATA-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Word t, lane k lives at address t*NUM + k.
    always_comb begin
        for (int k = 0; k < NUM; k++) begin
            rdata[k] = mem_q[{raddr, LANE_AW'(k)}];
        end
    end

endmodule

// File: rtl/fft_in_framer.sv
// Ping-pong frame buffer feeding the stage-01 butterfly with NUM-lane words per frame.
module fft_in_framer
    import fft_pkg::*;
#(
    parameter int GAP = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [IN_WIDTH-1:0] s_re,
    input  logic signed [IN_WIDTH-1:0] s_im,
    input  logic                       s_last,
    input  logic                       hold,
    output logic signed [IN_WIDTH-1:0] dout_i [0:NUM-1],
    output logic signed [IN_WIDTH-1:0] dout_q [0:NUM-1],
    output logic                       valid_out,
    output logic                       frame_err
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    bank_state_t      bank_q [2];
    bank_state_t      bank_d [2];
    logic             wb_q, wb_d, rb_q, rb_d;
    logic [WR_AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [RD_AW-1:0] rd_cnt_q, rd_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    rd_state_t        rd_st_q, rd_st_d;
    logic             err_d;

    logic             xfer, last_slot;
    logic             start_drain, rd_act, drain_done;

    logic                       valid_q, err_q;
    logic signed [IN_WIDTH-1:0] dout_i_q [0:NUM-1];
    logic signed [IN_WIDTH-1:0] dout_q_q [0:NUM-1];

    sample_t rdata0 [0:NUM-1];
    sample_t rdata1 [0:NUM-1];
    sample_t rd_sel [0:NUM-1];

    assign s_ready   = !rst && (bank_q[wb_q] == BK_EMPTY || bank_q[wb_q] == BK_FILL);
    assign xfer      = s_valid && s_ready;
    assign last_slot = (wr_cnt_q == WR_AW'(DATA - 1));

    fft_frame_bank u_bank0 (
        .clk   (clk),
        .we    (xfer && !wb_q),
        .waddr (wr_cnt_q),
        .wdata (pack_sample(s_re, s_im)),
        .raddr (rd_cnt_q),
        .rdata (rdata0)
    );

    fft_frame_bank u_bank1 (
        .clk   (clk),
        .we    (xfer && wb_q),
        .waddr (wr_cnt_q),
        .wdata (pack_sample(s_re, s_im)),
        .raddr (rd_cnt_q),
        .rdata (rdata1)
    );

    // Read FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_st_q <= RD_IDLE;
        end else begin
            rd_st_q <= rd_st_d;
        end
    end

    // Read FSM: next state
    always_comb begin
        rd_st_d = rd_st_q;
        case (rd_st_q)
            RD_IDLE:  if (bank_q[rb_q] == BK_FULL && !hold) rd_st_d = RD_DRAIN;
            RD_DRAIN: if (rd_cnt_q == RD_AW'(COUNT - 1))    rd_st_d = RD_GAP;
            RD_GAP:   if (gap_cnt_q == GAP_W'(GAP - 1))     rd_st_d = RD_IDLE;
            default:  rd_st_d = RD_IDLE;
        endcase
    end

    // Read FSM: outputs
    always_comb begin
        start_drain = (rd_st_q == RD_IDLE) && (bank_q[rb_q] == BK_FULL) && !hold;
        rd_act      = (rd_st_q == RD_DRAIN);
        drain_done  = rd_act && (rd_cnt_q == RD_AW'(COUNT - 1));
    end

    // Write-side updates come last so they win a same-edge free and fill.
    always_comb begin
        bank_d    = bank_q;
        wb_d      = wb_q;
        rb_d      = rb_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        gap_cnt_d = (rd_st_q == RD_GAP) ? gap_cnt_q + GAP_W'(1) : '0;
        err_d     = 1'b0;

        if (start_drain) begin
            bank_d[rb_q] = BK_DRAIN;
            rd_cnt_d     = '0;
        end
        if (rd_act) begin
            rd_cnt_d = rd_cnt_q + RD_AW'(1);
            if (drain_done) begin
                bank_d[rb_q] = BK_EMPTY;
                rb_d         = !rb_q;
            end
        end

        if (xfer) begin
            if (last_slot && s_last) begin
                bank_d[wb_q] = BK_FULL;
                wb_d         = !wb_q;
                wr_cnt_d     = '0;
            end else if (last_slot || s_last) begin
                bank_d[wb_q] = BK_EMPTY;
                wr_cnt_d     = '0;
                err_d        = 1'b1;
            end else begin
                bank_d[wb_q] = BK_FILL;
                wr_cnt_d     = wr_cnt_q + WR_AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0] <= BK_EMPTY;
            bank_q[1] <= BK_EMPTY;
            wb_q      <= 1'b0;
            rb_q      <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            bank_q    <= bank_d;
            wb_q      <= wb_d;
            rb_q      <= rb_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM; k++) begin
            rd_sel[k] = rb_q ? rdata1[k] : rdata0[k];
        end
    end

    // Output register: lanes forced to zero outside a burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < NUM; k++) begin
                dout_i_q[k] <= '0;
                dout_q_q[k] <= '0;
            end
        end else begin
            valid_q <= rd_act;
            err_q   <= err_d;
            for (int k = 0; k < NUM; k++) begin
                dout_i_q[k] <= rd_act ? sample_re(rd_sel[k]) : '0;
                dout_q_q[k] <= rd_act ? sample_im(rd_sel[k]) : '0;
            end
        end
    end

    assign valid_out = valid_q;
    assign frame_err = err_q;
    assign dout_i    = dout_i_q;
    assign dout_q    = dout_q_q;

endmodule

// File: tb/tb_fft_in_framer.sv
// Directed bench for fft_in_framer: framing, bursts, hold backpressure, errors, reset.
module tb_fft_in_framer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic hold = 1'b0;
    logic signed [9:0] s_re = '0;
    logic signed [9:0] s_im = '0;
    logic s_ready, valid_out, frame_err;
    logic signed [9:0] dout_i [0:15];
    logic signed [9:0] dout_q [0:15];

    fft_in_framer #(.GAP(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_re      (s_re),
        .s_im      (s_im),
        .s_last    (s_last),
        .hold      (hold),
        .dout_i    (dout_i),
        .dout_q    (dout_q),
        .valid_out (valid_out),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_assert = 0;
    int n_fail = 0;
    int stalls = 0;
    int last_acc = 0;

    // Burst monitor, sampled on the falling edge.
    int bcount = 0, cur = 0, low_run = 0, min_gap = 1000, err_pulses = 0, zero_viol = 0;
    int blen [10];
    int bstart [10];
    logic signed [9:0] cre [10][16][16];
    logic signed [9:0] cim [10][16][16];
    logic prev_v = 1'b0;

    always @(negedge clk) begin
        if (valid_out) begin
            if (!prev_v) begin
                if (bcount > 0 && low_run < min_gap) min_gap = low_run;
                if (bcount < 10) bstart[bcount] = cyc;
                cur = 0;
            end
            if (cur < 16 && bcount < 10) begin
                for (int k = 0; k < 16; k++) begin
                    cre[bcount][cur][k] = dout_i[k];
                    cim[bcount][cur][k] = dout_q[k];
                end
            end
            cur++;
        end else begin
            if (prev_v) begin
                if (bcount < 10) blen[bcount] = cur;
                bcount++;
                low_run = 1;
            end else begin
                low_run++;
            end
            for (int k = 0; k < 16; k++)
                if (dout_i[k] !== 10'sd0 || dout_q[k] !== 10'sd0) zero_viol++;
        end
        if (frame_err) err_pulses++;
        prev_v = valid_out;
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [9:0] exp_re(input int f, input int n);
        return 10'(n - 128 + 7 * f);
    endfunction

    function automatic logic signed [9:0] exp_im(input int n);
        return 10'(128 - n);
    endfunction

    function automatic int burst_mism(input int b, input int f);
        int m = 0;
        for (int t = 0; t < 16; t++)
            for (int k = 0; k < 16; k++)
                if (cre[b][t][k] !== exp_re(f, 16 * t + k) || cim[b][t][k] !== exp_im(16 * t + k))
                    m++;
        return m;
    endfunction

    task automatic send_sample(input logic signed [9:0] re, input logic signed [9:0] im,
                               input logic last);
        int waitc = 0;
        s_valid = 1'b1;
        s_re = re;
        s_im = im;
        s_last = last;
        while (!s_ready && waitc < 2000) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc > 0) stalls++;
        check("send_timeout", (waitc < 2000) ? 1 : 0, 1);
        @(posedge clk);
        #1;
        last_acc = cyc;
    endtask

    task automatic send_frame(input int f, input int len, input int last_at);
        for (int n = 0; n < len; n++)
            send_sample(exp_re(f, n), exp_im(n), (n == last_at));
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_bursts(input int target);
        int w = 0;
        while (bcount < target && w < 3000) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("burst_wait", (bcount >= target) ? 1 : 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input logic level);
        int w = 0;
        while (valid_out !== level && w < 3000) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("valid_wait", (valid_out === level) ? 1 : 0, 1);
    endtask

    int e0;

    initial begin
        // Reset state
        idle(3);
        check("rst_ready", s_ready, 0);
        check("rst_valid", valid_out, 0);
        check("rst_err", frame_err, 0);
        check("rst_dout_i0", dout_i[0], 0);
        check("rst_dout_q15", dout_q[15], 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", s_ready, 1);

        // Single frame: ramp, latency and lane mapping
        send_frame(0, 256, 255);
        idle(30);
        check("single_bursts", bcount, 1);
        check("single_len", blen[0], 16);
        check("single_latency", bstart[0] - last_acc, 2);
        check("single_data", burst_mism(0, 0), 0);
        check("w3l5_re", cre[0][3][5], -75);
        check("w3l5_im", cim[0][3][5], 75);
        check("w5l5_re", cre[0][5][5], -43);
        check("w5l5_im", cim[0][5][5], 43);
        check("single_err", err_pulses, 0);

        // Back-to-back frames at full rate
        stalls = 0;
        send_frame(1, 256, 255);
        send_frame(2, 256, 255);
        send_frame(3, 256, 255);
        wait_bursts(4);
        idle(4);
        check("b2b_stalls", stalls, 0);
        check("b2b_len1", blen[1], 16);
        check("b2b_len2", blen[2], 16);
        check("b2b_len3", blen[3], 16);
        check("b2b_data1", burst_mism(1, 1), 0);
        check("b2b_data2", burst_mism(2, 2), 0);
        check("b2b_data3", burst_mism(3, 3), 0);
        check("b2b_gap_ok", (min_gap >= 1) ? 1 : 0, 1);

        // Backpressure through hold
        hold = 1'b1;
        send_frame(4, 256, 255);
        send_frame(5, 256, 255);
        check("hold_ready_low", s_ready, 0);
        idle(10);
        check("hold_no_burst", bcount, 4);
        check("hold_ready_still_low", s_ready, 0);
        @(negedge clk);
        hold = 1'b0;
        wait_valid(1'b1);
        check("hold_ready_in_burst", s_ready, 0);
        wait_valid(1'b0);
        check("hold_ready_after", s_ready, 1);
        wait_bursts(6);
        idle(4);
        check("hold_len4", blen[4], 16);
        check("hold_len5", blen[5], 16);
        check("hold_data4", burst_mism(4, 4), 0);
        check("hold_data5", burst_mism(5, 5), 0);

        // Early s_last drops the frame
        e0 = err_pulses;
        send_frame(6, 101, 100);
        idle(30);
        check("early_err", err_pulses - e0, 1);
        check("early_no_burst", bcount, 6);
        send_frame(7, 256, 255);
        wait_bursts(7);
        idle(4);
        check("early_next_len", blen[6], 16);
        check("early_next_data", burst_mism(6, 7), 0);

        // Missing s_last drops the frame
        e0 = err_pulses;
        send_frame(8, 256, -1);
        idle(30);
        check("miss_err", err_pulses - e0, 1);
        check("miss_no_burst", bcount, 7);
        check("miss_ready", s_ready, 1);

        // Reset in the middle of a drain
        send_frame(8, 256, 255);
        wait_valid(1'b1);
        idle(7);
        check("mid_drain_valid", valid_out, 1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_cut_valid", valid_out, 0);
        check("rst_cut_dout_i", dout_i[3], 0);
        check("rst_cut_dout_q", dout_q[3], 0);
        check("rst_cut_ready", s_ready, 0);
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_ready", s_ready, 1);
        check("rst_trunc_len", (blen[7] < 16) ? 1 : 0, 1);
        send_frame(9, 256, 255);
        wait_bursts(9);
        idle(4);
        check("post_rst_len", blen[8], 16);
        check("post_rst_data", burst_mism(8, 9), 0);
        check("zero_outside_burst", zero_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
